norm_ctrl: RTL and testbench

NORM_CTRL -- requirements
Module: norm_ctrl

---
 rtl/norm_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_norm_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_ctrl.sv
// -----------------------------------------------------------------------------
// norm_ctrl -- post-addition normalization controller.
//
// Accepts one unnormalized adder result at a time and left-normalizes it using
// the shift count predicted by an external leading-one predictor (LOP_nbit).
// The operand signs, mantissas and exponent difference are captured on accept
// and driven out on the lop_* ports; the LOP answer comes back on lop_shift
// and is sampled one cycle later.
//
// Optional feature macro: NORM_CORRECT_EN
//   defined   : a CORRECT state follows SHIFT and fixes a one-position LOP
//               under-prediction (result still has MSB clear).
//   undefined : SHIFT goes straight to DONE and the LOP count is taken as exact.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are high. in_ready is high only in IDLE; out_valid is high
// only in DONE, and all result outputs stay frozen there until out_ready.
//
// Ports
//   clk, n_rst            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   operation offer / controller idle
//   sign1, sign2          operand signs
//   op1, op2              aligned operand mantissas (MANT_W)
//   exp_diff              operand exponent difference (EXP_W)
//   mant_in, exp_in       unnormalized mantissa / exponent
//   lop_sign1..lop_exp_diff  registered drive to the external LOP
//   lop_shift             predicted left-shift count from the LOP (8 bits)
//   out_valid / out_ready result valid / consumer takes result
//   mant_out, exp_out     normalized mantissa / exponent
//   zero                  result mantissa is zero
//   uflow                 exponent clamped at zero during normalization
//   fsm_state             current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module norm_ctrl #(
    parameter int MANT_W = 8,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign1,
    input  logic              sign2,
    input  logic [MANT_W-1:0] op1,
    input  logic [MANT_W-1:0] op2,
    input  logic [EXP_W-1:0]  exp_diff,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              lop_sign1,
    output logic              lop_sign2,
    output logic [MANT_W-1:0] lop_op1,
    output logic [MANT_W-1:0] lop_op2,
    output logic [EXP_W-1:0]  lop_exp_diff,
    input  logic [7:0]        lop_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero,
    output logic              uflow,
    output logic [2:0]        fsm_state
);

    // Width wide enough to compare a shift count against any exponent.
    localparam int CW = (EXP_W > 8) ? EXP_W : 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREDICT = 3'd1,
        SHIFT   = 3'd2,
`ifdef NORM_CORRECT_EN
        CORRECT = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [MANT_W-1:0] mant_q;
    logic [EXP_W-1:0]  exp_q;
    logic [7:0]        shift_q;

    // Combinational helpers for the shift step.
    logic [7:0]        shift_sat;
    logic              clamp;
    logic [7:0]        shift_amt;
    logic [MANT_W-1:0] mant_shl;
    logic [EXP_W-1:0]  exp_sub;

    assign fsm_state = state;

    always_comb begin
        shift_sat = lop_shift;
        // A shift of MANT_W or more would clear the mantissa entirely.
        if (lop_shift > 8'(MANT_W - 1)) begin
            shift_sat = 8'(MANT_W - 1);
        end
        // If the exponent cannot absorb the full shift, shift only by exp
        // and pin the exponent at zero (underflow).
        clamp     = CW'(shift_q) > CW'(exp_q);
        shift_amt = clamp ? 8'(exp_q) : shift_q;
        mant_shl  = mant_q << shift_amt;
        exp_sub   = clamp ? '0 : (exp_q - EXP_W'(shift_q));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            mant_q       <= '0;
            exp_q        <= '0;
            shift_q      <= '0;
            mant_out     <= '0;
            exp_out      <= '0;
            zero         <= 1'b0;
            uflow        <= 1'b0;
            lop_sign1    <= 1'b0;
            lop_sign2    <= 1'b0;
            lop_op1      <= '0;
            lop_op2      <= '0;
            lop_exp_diff <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lop_sign1    <= sign1;
                        lop_sign2    <= sign2;
                        lop_op1      <= op1;
                        lop_op2      <= op2;
                        lop_exp_diff <= exp_diff;
                        mant_q       <= mant_in;
                        exp_q        <= exp_in;
                        in_ready     <= 1'b0;
                        state        <= PREDICT;
                    end
                end

                PREDICT: begin
                    if (mant_q == '0) begin
                        mant_out  <= '0;
                        exp_out   <= '0;
                        zero      <= 1'b1;
                        uflow     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // LOP has had a full cycle to settle on the lop_* drive.
                        shift_q <= shift_sat;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    mant_q <= mant_shl;
                    exp_q  <= exp_sub;
                    if (clamp) begin
                        // Underflowed results are final; no correction step.
                        mant_out  <= mant_shl;
                        exp_out   <= '0;
                        zero      <= 1'b0;
                        uflow     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
`ifdef NORM_CORRECT_EN
                        state <= CORRECT;
`else
                        mant_out  <= mant_shl;
                        exp_out   <= exp_sub;
                        zero      <= 1'b0;
                        uflow     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end

`ifdef NORM_CORRECT_EN
                CORRECT: begin
                    zero      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                    if (!mant_q[MANT_W-1] && (exp_q != '0)) begin
                        // LOP predicted one position short.
                        mant_out <= mant_q << 1;
                        exp_out  <= exp_q - EXP_W'(1);
                        uflow    <= 1'b0;
                    end else if (!mant_q[MANT_W-1]) begin
                        // Still unnormalized but exponent already at zero.
                        mant_out <= mant_q;
                        exp_out  <= exp_q;
                        uflow    <= 1'b1;
                    end else begin
                        mant_out <= mant_q;
                        exp_out  <= exp_q;
                        uflow    <= 1'b0;
                    end
                end
`endif

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_norm_ctrl -- directed scoreboard bench for norm_ctrl.
// The driver pushes the hand-computed result of every operation into exp_q;
// a monitor pops and compares whenever out_valid is presented, including the
// number of cycles since the accept edge.
// -----------------------------------------------------------------------------
module tb_norm_ctrl;

    localparam int W = 22; // {latency[3:0], mant[7:0], exp[7:0], zero, uflow}

`ifdef NORM_CORRECT_EN
    localparam int LC = 4; // latency of a non-zero, non-clamped result
`else
    localparam int LC = 3;
`endif

    logic       clk;
    logic       n_rst;
    logic       in_valid;
    logic       in_ready;
    logic       sign1, sign2;
    logic [7:0] op1, op2;
    logic [7:0] exp_diff;
    logic [7:0] mant_in;
    logic [7:0] exp_in;
    logic       lop_sign1, lop_sign2;
    logic [7:0] lop_op1, lop_op2;
    logic [7:0] lop_exp_diff;
    logic [7:0] lop_shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] mant_out;
    logic [7:0] exp_out;
    logic       zero;
    logic       uflow;
    logic [2:0] fsm_state;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    norm_ctrl #(.MANT_W(8), .EXP_W(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign1(sign1), .sign2(sign2), .op1(op1), .op2(op2),
        .exp_diff(exp_diff), .mant_in(mant_in), .exp_in(exp_in),
        .lop_sign1(lop_sign1), .lop_sign2(lop_sign2),
        .lop_op1(lop_op1), .lop_op2(lop_op2), .lop_exp_diff(lop_exp_diff),
        .lop_shift(lop_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .mant_out(mant_out), .exp_out(exp_out),
        .zero(zero), .uflow(uflow), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit armed;
    bit seen;
    int cyc;

    always @(posedge clk) begin
        if (n_rst && in_valid && in_ready) begin
            armed = 1'b1;
            cyc   = 0;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!n_rst) begin
            armed = 1'b0;
            seen  = 1'b0;
        end else begin
            if (armed) cyc++;
            if (out_valid && !seen) begin
                seen  = 1'b1;
                armed = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc, int'(e[21:18]));
                    chk("mant_out", int'(mant_out), int'(e[17:10]));
                    chk("exp_out", int'(exp_out), int'(e[9:2]));
                    chk("zero", int'(zero), int'(e[1]));
                    chk("uflow", int'(uflow), int'(e[0]));
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_mant_out"}, int'(mant_out), 0);
        chk({tag, "_exp_out"}, int'(exp_out), 0);
        chk({tag, "_zero"}, int'(zero), 0);
        chk({tag, "_uflow"}, int'(uflow), 0);
        chk({tag, "_lop"}, int'({lop_sign1, lop_sign2, lop_op1, lop_op2, lop_exp_diff}), 0);
    endtask

    task automatic issue(input logic [7:0] m, input logic [7:0] e, input logic [7:0] lop,
                         input logic [7:0] o1, input logic [7:0] o2,
                         input logic s1, input logic s2, input logic [7:0] ed,
                         input logic [7:0] em, input logic [7:0] ee,
                         input logic ez, input logic eu, input int lat);
        int i;
        logic [3:0] l4;
        i = 0;
        @(negedge clk);
        while (!in_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        mant_in   = m;
        exp_in    = e;
        lop_shift = lop;
        op1       = o1;
        op2       = o2;
        sign1     = s1;
        sign2     = s2;
        exp_diff  = ed;
        in_valid  = 1'b1;
        l4 = 4'(lat);
        exp_q.push_back({l4, em, ee, ez, eu});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lop_drive", int'({lop_sign1, lop_sign2, lop_op1, lop_op2, lop_exp_diff}),
            int'({s1, s2, o1, o2, ed}));
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0 || out_valid) chk("drain_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        failures  = 0;
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sign1 = 1'b0; sign2 = 1'b0;
        op1 = '0; op2 = '0; exp_diff = '0;
        mant_in = '0; exp_in = '0; lop_shift = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        n_rst = 1'b1;
        @(negedge clk);

        // Basic normalization, LOP exact.
        issue(8'h44, 8'd10, 8'd1, 8'h45, 8'h01, 1'b0, 1'b1, 8'd3,
              8'h88, 8'd9, 1'b0, 1'b0, LC);
        wait_idle();

        // LOP one short: corrected only when the CORRECT state exists.
`ifdef NORM_CORRECT_EN
        issue(8'h44, 8'd10, 8'd0, 8'h10, 8'h20, 1'b1, 1'b0, 8'd1,
              8'h88, 8'd9, 1'b0, 1'b0, 4);
`else
        issue(8'h44, 8'd10, 8'd0, 8'h10, 8'h20, 1'b1, 1'b0, 8'd1,
              8'h44, 8'd10, 1'b0, 1'b0, 3);
`endif
        wait_idle();

        // Shift larger than exponent: clamp and underflow, no correction.
        issue(8'h01, 8'd3, 8'd7, 8'h0f, 8'h0e, 1'b1, 1'b1, 8'd2,
              8'h08, 8'd0, 1'b0, 1'b1, 3);
        wait_idle();

        // Zero result.
        issue(8'h00, 8'd5, 8'd3, 8'h33, 8'h33, 1'b0, 1'b1, 8'd0,
              8'h00, 8'd0, 1'b1, 1'b0, 2);
        wait_idle();

        // LOP count beyond width saturates to 7.
        issue(8'h01, 8'd20, 8'd200, 8'h81, 8'h80, 1'b0, 1'b0, 8'd7,
              8'h80, 8'd13, 1'b0, 1'b0, LC);
        wait_idle();

        // Shift equal to exponent: exp reaches 0 with MSB still clear.
`ifdef NORM_CORRECT_EN
        issue(8'h01, 8'd2, 8'd2, 8'h02, 8'h01, 1'b0, 1'b1, 8'd4,
              8'h04, 8'd0, 1'b0, 1'b1, 4);
`else
        issue(8'h01, 8'd2, 8'd2, 8'h02, 8'h01, 1'b0, 1'b1, 8'd4,
              8'h04, 8'd0, 1'b0, 1'b0, 3);
`endif
        wait_idle();

        // Under-predicted by one with headroom in the exponent.
`ifdef NORM_CORRECT_EN
        issue(8'h20, 8'd5, 8'd1, 8'h50, 8'h30, 1'b0, 1'b1, 8'd5,
              8'h80, 8'd3, 1'b0, 1'b0, 4);
`else
        issue(8'h20, 8'd5, 8'd1, 8'h50, 8'h30, 1'b0, 1'b1, 8'd5,
              8'h40, 8'd4, 1'b0, 1'b0, 3);
`endif
        wait_idle();

        // Back-pressure in DONE: outputs frozen, new offers ignored.
        out_ready = 1'b0;
        issue(8'h12, 8'd6, 8'd3, 8'h5a, 8'ha5, 1'b1, 1'b0, 8'd6,
              8'h90, 8'd3, 1'b0, 1'b0, LC);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("hold_reach_done", int'(out_valid), 1);
        mant_in  = 8'h00;
        exp_in   = 8'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_mant", int'(mant_out), 8'h90);
            chk("hold_exp", int'(exp_out), 3);
            chk("hold_flags", int'({zero, uflow}), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        wait_idle();

        // Reset pulse while in SHIFT discards the operation.
        issue(8'h03, 8'd9, 8'd4, 8'h11, 8'h22, 1'b1, 1'b1, 8'd8,
              8'h30, 8'd5, 1'b0, 1'b0, LC);
        @(posedge clk);
        #1;
        chk("mid_state_shift", int'(fsm_state), 2);
        n_rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        chk_reset("rst_hold");
        n_rst = 1'b1;
        @(negedge clk);

        // Next operation after reset completes normally.
        issue(8'h03, 8'd9, 8'd6, 8'h44, 8'h04, 1'b0, 1'b1, 8'd9,
              8'hc0, 8'd3, 1'b0, 1'b0, LC);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
